fetch_unit: RTL and testbench

//  Instruction-fetch stage ahead of the IF/ID register. Owns the PC and issues word reads to

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_instr_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// Optional perf counters: define FETCH_PERF_CNT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FULL
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_unit_instr_fifo.sv
// Small registered FIFO of fetched {pc, instr} entries.
// Flush has priority over push and pop.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    // Empty head reads as zero so decode never sees stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem reads, output FIFO.
// Optional perf counters: define FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] issue_pc_q;
    logic            outstanding_q;
    logic            drop_q;

    logic            issue;
    logic            resp;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign issue       = imem_req & imem_gnt;
    assign resp        = imem_rvalid & outstanding_q;
    assign push        = resp & ~drop_q & ~redirect_en;
    assign instr_valid = ~fifo_empty & ~redirect_en;
    assign pop         = instr_valid & instr_ready;
    assign imem_addr   = fetch_pc_q;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign wr_entry    = '{pc: issue_pc_q, instr: imem_rdata};

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                imem_req = ~outstanding_q & ~fifo_full & ~redirect_en;
                if (!redirect_en && !outstanding_q &&
                    count == CW'(FIFO_DEPTH))
                    state_d = S_FULL;
            end
            S_FULL: begin
                if (pop || redirect_en) state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= RESET_PC;
            issue_pc_q    <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect_en) begin
                // A response landing now is consumed and thrown away.
                fetch_pc_q    <= redirect_pc & ~XLEN'(3);
                outstanding_q <= outstanding_q & ~imem_rvalid;
                drop_q        <= outstanding_q & ~imem_rvalid;
            end else begin
                if (resp) begin
                    outstanding_q <= 1'b0;
                    drop_q        <= 1'b0;
                end
                if (issue) begin
                    outstanding_q <= 1'b1;
                    issue_pc_q    <= fetch_pc_q;
                    fetch_pc_q    <= fetch_pc_q + XLEN'(PC_STEP);
                end
            end
        end
    end

    instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_en),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef FETCH_PERF_CNT_EN
    logic dropped;

    assign dropped = resp & (drop_q | redirect_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushed <= perf_flushed + 32'(dropped) +
                            (redirect_en ? 32'(count) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Optional perf counters checked when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int total = 0;
    int bad = 0;

    logic        mem_on;
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          n_issue;
    logic [31:0] iss_q[$];

    logic        o_req;
    logic [31:0] o_addr;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    // One cycle: drive inputs after negedge, sample, then wait next negedge.
    task automatic cyc(input logic rdy, input logic gnt,
                       input logic redir, input logic [31:0] rpc);
        instr_ready = rdy;
        imem_gnt    = gnt;
        redirect_en = redir;
        redirect_pc = rpc;
        imem_rvalid = mem_pend & mem_on;
        imem_rdata  = mem_pend ? (mem_addr >> 2) : 32'h0;
        #1;
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = instr_valid;
        o_instr = instr;
        o_pc    = instr_pc;
        if (imem_rvalid) mem_pend = 1'b0;
        if (imem_req && imem_gnt) begin
            mem_pend = 1'b1;
            mem_addr = imem_addr;
            n_issue++;
            iss_q.push_back(imem_addr);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        mem_on      = 1'b1;
        mem_pend    = 1'b0;
        mem_addr    = 32'h0;
        n_issue     = 0;
        iss_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 1, 0, 32'h0);
        total++; if (o_req !== 1'b0) begin bad++; $display("FAIL boot_req: got %b want 0", o_req); end
        total++; if (dut.state_q !== S_RUN) begin bad++; $display("FAIL boot_state: got %0d want %0d", dut.state_q, S_RUN); end
    endtask

    task automatic test_stream();
        logic [31:0] pcs[$];
        logic [31:0] ins[$];
        int first;
        first = -1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cyc(1, 1, 0, 32'h0);
            if (o_valid) begin
                pcs.push_back(o_pc);
                ins.push_back(o_instr);
                if (first < 0) first = c;
            end
        end
        total++; if (iss_q.size() !== 4) begin bad++; $display("FAIL stream_nissue: got %0d want 4", iss_q.size()); end
        for (int i = 0; i < iss_q.size() && i < 4; i++) begin
            total++; if (iss_q[i] !== 32'(i * 4)) begin bad++; $display("FAIL stream_addr%0d: got %h want %h", i, iss_q[i], i * 4); end
        end
        total++; if (pcs.size() !== 3) begin bad++; $display("FAIL stream_npop: got %0d want 3", pcs.size()); end
        for (int i = 0; i < pcs.size() && i < 3; i++) begin
            total++; if (pcs[i] !== 32'(i * 4)) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", i, pcs[i], i * 4); end
            total++; if (ins[i] !== 32'(i)) begin bad++; $display("FAIL stream_instr%0d: got %h want %h", i, ins[i], i); end
        end
        total++; if (first !== 3) begin bad++; $display("FAIL stream_latency: got %0d want 3", first); end
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 12; c++) cyc(0, 1, 0, 32'h0);
        total++; if (n_issue !== 4) begin bad++; $display("FAIL full_nissue: got %0d want 4", n_issue); end
        total++; if (o_req !== 1'b0) begin bad++; $display("FAIL full_req: got %b want 0", o_req); end
        total++; if (dut.state_q !== S_FULL) begin bad++; $display("FAIL full_state: got %0d want %0d", dut.state_q, S_FULL); end
        cyc(1, 1, 0, 32'h0);
        total++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin bad++; $display("FAIL full_pop: got v=%b pc=%h want v=1 pc=0", o_valid, o_pc); end
        for (int c = 0; c < 6; c++) cyc(0, 1, 0, 32'h0);
        total++; if (n_issue !== 5) begin bad++; $display("FAIL full_refill: got %0d want 5", n_issue); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL full_refill_addr: got %h want 10", mem_addr); end
        total++; if (dut.state_q !== S_FULL) begin bad++; $display("FAIL full_state2: got %0d want %0d", dut.state_q, S_FULL); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 8; c++) cyc(0, 1, 0, 32'h0);
        total++; if (dut.u_fifo.count !== 3'd3 || mem_pend !== 1'b1) begin bad++; $display("FAIL redir_setup: got cnt=%0d pend=%b want 3/1", dut.u_fifo.count, mem_pend); end
        mem_on = 1'b0;
        cyc(1, 1, 1, 32'h40);
        total++; if (o_valid !== 1'b0 || o_req !== 1'b0) begin bad++; $display("FAIL redir_cycle: got v=%b req=%b want 0/0", o_valid, o_req); end
        mem_on = 1'b1;
        cyc(1, 1, 0, 32'h0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL redir_after: got v=%b want 0", o_valid); end
        cyc(1, 1, 0, 32'h0);
        total++; if (o_req !== 1'b1 || o_addr !== 32'h40) begin bad++; $display("FAIL redir_req: got req=%b addr=%h want 1/40", o_req, o_addr); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL redir_drop: got v=%b want 0", o_valid); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_flushed !== 32'd4) begin bad++; $display("FAIL perf_flushed: got %0d want 4", perf_flushed); end
        total++; if (perf_fetched !== 32'd3) begin bad++; $display("FAIL perf_fetched: got %0d want 3", perf_fetched); end
`endif
        cyc(1, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h0);
        total++; if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_instr !== 32'h10) begin bad++; $display("FAIL redir_head: got v=%b pc=%h i=%h want 1/40/10", o_valid, o_pc, o_instr); end
    endtask

    task automatic test_align_wrap();
        do_reset();
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 1, 32'h103);
        total++; if (o_req !== 1'b0) begin bad++; $display("FAIL align_noreq: got %b want 0", o_req); end
        cyc(0, 1, 0, 32'h0);
        total++; if (o_req !== 1'b1 || o_addr !== 32'h100) begin bad++; $display("FAIL align_addr: got req=%b addr=%h want 1/100", o_req, o_addr); end
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 32'h0);
        total++; if (o_addr !== 32'hFFFF_FFFC || o_valid !== 1'b0) begin bad++; $display("FAIL wrap_top: got addr=%h v=%b want fffffffc/0", o_addr, o_valid); end
        cyc(0, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h0);
        total++; if (o_req !== 1'b1 || o_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/0", o_req, o_addr); end
        total++; if (o_pc !== 32'hFFFF_FFFC || o_instr !== 32'h3FFF_FFFF) begin bad++; $display("FAIL wrap_head: got pc=%h i=%h want fffffffc/3fffffff", o_pc, o_instr); end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 32'h0);
            total++; if (o_req !== 1'b1 || o_addr !== 32'h4) begin bad++; $display("FAIL stall%0d: got req=%b addr=%h want 1/4", k, o_req, o_addr); end
        end
        total++; if (n_issue !== 1 || dut.u_fifo.count !== 3'd1) begin bad++; $display("FAIL stall_nopush: got iss=%0d cnt=%0d want 1/1", n_issue, dut.u_fifo.count); end
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 0, 32'h0);
        total++; if (n_issue !== 2 || dut.u_fifo.count !== 3'd2) begin bad++; $display("FAIL stall_resume: got iss=%0d cnt=%0d want 2/2", n_issue, dut.u_fifo.count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 4; c++) cyc(0, 1, 0, 32'h0);
        mem_on = 1'b0;
        cyc(0, 1, 0, 32'h0);
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL arst_req: got req=%b addr=%h want 0/0", imem_req, imem_addr); end
        total++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL arst_out: got v=%b i=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc); end
        @(negedge clk);
        rst = 1'b1;
        mem_on = 1'b1;
        cyc(1, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h0);
        total++; if (o_req !== 1'b1 || o_addr !== 32'h0 || o_valid !== 1'b0) begin bad++; $display("FAIL arst_first: got req=%b addr=%h v=%b want 1/0/0", o_req, o_addr, o_valid); end
        cyc(1, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h0);
        total++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== 32'h0) begin bad++; $display("FAIL arst_head: got v=%b pc=%h i=%h want 1/0/0", o_valid, o_pc, o_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_align_wrap();
        test_gnt_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
